// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial adder: FSM state encodings
//   (also used by the testbench to probe the controller state) and a
//   helper that sizes the step counter.
package serial_adder_ctrl_pkg;

  // FSM state encodings
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Step counter width: enough bits to count 0..width-1, at least one bit.
  function automatic int cnt_bits(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// fa_cell
//   1-bit full adder, purely combinational. This is the only arithmetic
//   in the serial adder datapath.
// Ports:
//   a, b  in   operand bits
//   ci    in   carry in
//   s     out  sum bit
//   co    out  carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ ci;
  assign co       = (a & b) | (ci & half_sum);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder. One full-adder cell and a carry flip-flop add two
//   WIDTH-bit operands LSB-first, one bit per clock. Operands are latched
//   on an accepted start, WIDTH add steps follow, then {Cout,Sum} is
//   published together with a one-cycle done pulse.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while idle
//   A, B   in   WIDTH-bit operands, sampled with an accepted start
//   Cin    in   carry in, sampled with an accepted start
//   busy   out  high while the add steps are running
//   done   out  one-cycle pulse, Sum/Cout valid
//   Sum    out  WIDTH-bit result, held until the next done
//   Cout   out  carry out, held like Sum
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             cout_reg;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] op_a_next;
  logic [WIDTH-1:0] op_b_next;

  fa_cell u_fa (
    .a  (op_a_reg[0]),
    .b  (op_b_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum bits enter at the MSB so that after WIDTH steps the first
  // (LSB) result bit has reached bit 0. Operands shift right, so the
  // adder always sees bit 0.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign acc_next[gi]  = acc_reg[gi+1];
      assign op_a_next[gi] = op_a_reg[gi+1];
      assign op_b_next[gi] = op_b_reg[gi+1];
    end
  endgenerate
  assign acc_next[WIDTH-1]  = fa_s;
  assign op_a_next[WIDTH-1] = 1'b0;
  assign op_b_next[WIDTH-1] = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_a_reg  <= A;
            op_b_reg  <= B;
            carry_reg <= Cin;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_reg   <= acc_next;
          op_a_reg  <= op_a_next;
          op_b_reg  <= op_b_next;
          carry_reg <= fa_co;
          if (cnt_reg == LAST_STEP) begin
            // Publish from the next-values so the final step's bit
            // and carry are included in the result.
            sum_reg   <= acc_next;
            cout_reg  <= fa_co;
            cnt_reg   <= '0;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg == S_SHIFT);
  assign done = (state_reg == S_DONE);
  assign Sum  = sum_reg;
  assign Cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Directed and random stimulus for serial_adder_ctrl (WIDTH=8) with a
//   cycle-count reference model compared against the DUT every cycle,
//   plus literal expectations for the hand-computed cases.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int total;
  int passed;
  int cyc;
  bit chk_en;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (op_a),
    .B     (op_b),
    .Cin   (cin),
    .busy  (busy),
    .done  (done),
    .Sum   (sum),
    .Cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    else
      passed++;
  endtask

  // Reference model: phase counts cycles since the accepting edge.
  // 0 = idle, 1..WIDTH = busy, WIDTH+1 = done cycle.
  int               m_phase;
  logic [WIDTH:0]   m_res;
  logic [WIDTH-1:0] m_sum;
  logic             m_cout;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_res   <= {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
        m_phase <= 1;
      end
    end else if (m_phase == WIDTH) begin
      {m_cout, m_sum} <= m_res;
      m_phase <= WIDTH + 1;
    end else if (m_phase == WIDTH + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, (m_phase >= 1 && m_phase <= WIDTH)});
      check("done", {31'd0, done}, {31'd0, (m_phase == WIDTH + 1)});
      check("sum", {24'd0, sum}, {24'd0, m_sum});
      check("cout", {31'd0, cout}, {31'd0, m_cout});
    end
  end

  // One add: pulse start, let inputs wander, wait (bounded) for done.
  // Returns at the negedge of the done cycle.
  task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ci, output logic [WIDTH-1:0] s,
                         output logic co, output int lat, output int nbusy);
    int t0;
    @(negedge clk);
    op_a = a; op_b = b; cin = ci; start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); cin = 1'($urandom);
    nbusy = 0; lat = -1; s = '0; co = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy) nbusy++;
      if (done) begin
        lat = cyc - t0;
        s = sum;
        co = cout;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] s;
    logic             co;
    int               lat;
    int               nbusy;
    int               ndone;
    int               acc_cyc[2];
    int               nacc;
    logic [WIDTH-1:0] dsum[2];
    bit               prev_busy;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic [WIDTH:0]   ref_sum;

    total = 0; passed = 0; chk_en = 1'b0;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_state", {30'd0, dut.state_reg}, {30'd0, S_IDLE});
    rst = 1'b0;

    // Test 1: 0F + 01 + 0
    run_add(8'h0F, 8'h01, 1'b0, s, co, lat, nbusy);
    $display("add A=0f B=01 Cin=0 -> Sum=%h Cout=%b lat=%0d busy=%0d", s, co, lat, nbusy);
    check("t1_sum", {24'd0, s}, 32'h10);
    check("t1_cout", {31'd0, co}, 32'd0);
    check("t1_model_sum", {24'd0, m_sum}, 32'h10);
    check("t1_latency", lat, WIDTH);
    check("t1_busy_cycles", nbusy, WIDTH);

    // Test 5: previous 0x10 held during a new add (33+44+1 = 78)
    @(negedge clk);
    op_a = 8'h33; op_b = 8'h44; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = 8'hAA; op_b = 8'h55;
    for (int i = 0; i < WIDTH; i++) begin
      check("t5_held_sum", {24'd0, sum}, 32'h10);
      @(negedge clk);
    end
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_sum", {24'd0, sum}, 32'h78);
    check("t5_cout", {31'd0, cout}, 32'd0);
    $display("add A=33 B=44 Cin=1 -> Sum=%h Cout=%b", sum, cout);

    // Test 2: full ripple and all-ones
    run_add(8'hFF, 8'h01, 1'b0, s, co, lat, nbusy);
    $display("add A=ff B=01 Cin=0 -> Sum=%h Cout=%b", s, co);
    check("t2a_sum", {24'd0, s}, 32'h00);
    check("t2a_cout", {31'd0, co}, 32'd1);
    run_add(8'hFF, 8'hFF, 1'b1, s, co, lat, nbusy);
    $display("add A=ff B=ff Cin=1 -> Sum=%h Cout=%b", s, co);
    check("t2b_sum", {24'd0, s}, 32'hFF);
    check("t2b_cout", {31'd0, co}, 32'd1);
    check("t2b_model_cout", {31'd0, m_cout}, 32'd1);

    // Test 3: start held 20 cycles, operands changing every cycle
    @(negedge clk);
    ndone = 0; nacc = 0; prev_busy = busy;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      op_a = 8'h20 + 8'(i);
      op_b = 8'(3 * i + 1);
      cin = 1'b0;
      @(negedge clk);
      if (busy && !prev_busy) begin
        if (nacc < 2) acc_cyc[nacc] = cyc;
        nacc++;
      end
      prev_busy = busy;
      if (done) begin
        if (ndone < 2) dsum[ndone] = sum;
        ndone++;
      end
    end
    start = 1'b0;
    $display("held start: accepts=%0d dones=%0d", nacc, ndone);
    check("t3_accepts", nacc, 2);
    check("t3_dones", ndone, 2);
    if (nacc >= 2) check("t3_accept_gap", acc_cyc[1] - acc_cyc[0], WIDTH + 2);
    if (ndone >= 2) begin
      check("t3_sum0", {24'd0, dsum[0]}, 32'h21);
      check("t3_sum1", {24'd0, dsum[1]}, 32'h49);
    end

    // Test 4: reset mid-add
    run_add(8'h0F, 8'h01, 1'b0, s, co, lat, nbusy);
    @(negedge clk);
    op_a = 8'h77; op_b = 8'h11; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_done", {31'd0, done}, 32'd0);
    check("t4_sum", {24'd0, sum}, 32'd0);
    check("t4_cout", {31'd0, cout}, 32'd0);
    check("t4_state", {30'd0, dut.state_reg}, {30'd0, S_IDLE});
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t4_no_done", ndone, 0);
    run_add(8'h5A, 8'h3C, 1'b1, s, co, lat, nbusy);
    $display("add after reset A=5a B=3c Cin=1 -> Sum=%h Cout=%b", s, co);
    check("t4_new_sum", {24'd0, s}, 32'h97);
    check("t4_new_cout", {31'd0, co}, 32'd0);

    // Test 6: random back-to-back adds
    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      run_add(ra, rb, rc, s, co, lat, nbusy);
      $display("rand %0d A=%h B=%h Cin=%b -> {Cout,Sum}=%h", n, ra, rb, rc, {co, s});
      check("rand_result", {23'd0, co, s}, {23'd0, ref_sum});
      check("rand_latency", lat, WIDTH);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
